isqrt_share_arbiter: RTL and testbench

//  Shares one pipelined isqrt unit (32-bit x in, 16-bit y out, in-order, fixed
//  or variable latency, no backpressure) between N_REQ requesters, e.g. several

---
 rtl/isqrt_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_isqrt_share_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_share_arbiter.sv
// rtl/isqrt_share_arbiter.sv - round-robin sharing of one pipelined isqrt unit among N_REQ requesters
//
// Purpose: issues operands from N_REQ requesters to a single in-order isqrt
// pipeline (round-robin, one issue per cycle), remembers the issuing requester
// in a tag FIFO and steers each returning result back to that requester.
//
// Ports:
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   req_vld[N_REQ]        per-requester operand valid
//   req_x[N_REQ*32]       operands, requester i at [32*i +: 32]
//   req_rdy[N_REQ]        one-hot grant (combinational), transfer on req_vld&req_rdy
//   rsp_vld[N_REQ]        one-cycle result strobe per requester
//   rsp_y[N_REQ*16]       results, requester i at [16*i +: 16], held between strobes
//   isqrt_x_vld, isqrt_x  issue strobe and operand to the isqrt unit
//   isqrt_y_vld, isqrt_y  result strobe and result from the isqrt unit
//   busy                  at least one operation in flight
//   err_orphan            sticky: a result arrived with nothing in flight

module isqrt_share_arbiter #(
    parameter int N_REQ        = 3,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [N_REQ*32-1:0]   req_x,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [N_REQ*16-1:0]   rsp_y,
    output logic                  isqrt_x_vld,
    output logic [31:0]           isqrt_x,
    input  logic                  isqrt_y_vld,
    input  logic [15:0]           isqrt_y,
    output logic                  busy,
    output logic                  err_orphan
);

    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = TW + 1;
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;

    logic [TW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [TW-1:0]         tag_mem [MAX_INFLIGHT];
    logic                  isqrt_x_vld_q;
    logic [31:0]           isqrt_x_q, isqrt_x_d;
    logic [N_REQ-1:0]      rsp_vld_q, rsp_vld_d;
    logic [N_REQ*16-1:0]   rsp_y_q, rsp_y_d;
    logic                  err_orphan_q;

    logic                  issue_ok;
    logic                  found;
    logic                  push;
    logic                  pop;
    logic [SW-1:0]         scan_idx;
    logic [TW-1:0]         gnt_tag;
    logic [TW-1:0]         rd_tag;

    // Round-robin scan starting at ptr_q. The full check uses the registered
    // count, so a slot freed by a pop only becomes usable the next cycle.
    always_comb begin
        req_rdy  = '0;
        found    = 1'b0;
        scan_idx = '0;
        issue_ok = (count_q < CW'(MAX_INFLIGHT));
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = SW'(ptr_q) + SW'(k);
            if (scan_idx >= SW'(N_REQ)) begin
                scan_idx = scan_idx - SW'(N_REQ);
            end
            if (issue_ok && !found && req_vld[scan_idx[TW-1:0]]) begin
                req_rdy[scan_idx[TW-1:0]] = 1'b1;
                found                     = 1'b1;
            end
        end
    end

    // Decode the one-hot grant into a tag and the operand to issue.
    always_comb begin
        gnt_tag   = '0;
        isqrt_x_d = isqrt_x_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_rdy[i]) begin
                gnt_tag   = TW'(i);
                isqrt_x_d = req_x[32*i +: 32];
            end
        end
        push  = |req_rdy;
        ptr_d = ptr_q;
        if (push) begin
            ptr_d = (gnt_tag == TW'(N_REQ - 1)) ? '0 : gnt_tag + 1'b1;
        end
    end

    // A result with an empty FIFO is an orphan: it pops nothing and is dropped.
    always_comb begin
        pop       = isqrt_y_vld && (count_q != '0);
        rd_tag    = tag_mem[rd_ptr_q];
        rsp_vld_d = '0;
        rsp_y_d   = rsp_y_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (pop && (rd_tag == TW'(i))) begin
                rsp_vld_d[i]         = 1'b1;
                rsp_y_d[16*i +: 16]  = isqrt_y;
            end
        end
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            isqrt_x_vld_q <= 1'b0;
            isqrt_x_q     <= '0;
            rsp_vld_q     <= '0;
            rsp_y_q       <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            isqrt_x_vld_q <= push;
            isqrt_x_q     <= isqrt_x_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_y_q       <= rsp_y_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (isqrt_y_vld && !pop) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= gnt_tag;
        end
    end

    assign isqrt_x_vld = isqrt_x_vld_q;
    assign isqrt_x     = isqrt_x_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_y       = rsp_y_q;
    assign busy        = (count_q != '0);
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// tb/tb_isqrt_share_arbiter.sv - self-checking bench for isqrt_share_arbiter
module tb_isqrt_share_arbiter;

    localparam int N  = 3;
    localparam int MI = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_vld;
    logic [N*32-1:0]   req_x;
    wire  [N-1:0]      req_rdy;
    wire  [N-1:0]      rsp_vld;
    wire  [N*16-1:0]   rsp_y;
    wire               isqrt_x_vld;
    wire  [31:0]       isqrt_x;
    wire               isqrt_y_vld;
    wire  [15:0]       isqrt_y;
    wire               busy;
    wire               err_orphan;

    logic              mdl_y_vld = 1'b0;
    logic [15:0]       mdl_y = '0;
    logic              man_y_vld;
    logic [15:0]       man_y;
    logic              model_en;
    logic              hold;
    int                lat;
    longint            cyc = 0;
    int                n_checks;
    int                n_fail;

    typedef struct { logic [15:0] y; longint due; } pend_t;
    typedef struct { int lane; logic [15:0] y; } exp_t;
    pend_t pq[$];

    assign isqrt_y_vld = model_en ? mdl_y_vld : man_y_vld;
    assign isqrt_y     = model_en ? mdl_y : man_y;

    isqrt_share_arbiter #(.N_REQ(N), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_y(rsp_y),
        .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
        .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        longint r = 0;
        longint t;
        for (int b = 15; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return r[15:0];
    endfunction

    // In-order isqrt pipeline with per-op latency 'lat'; 'hold' freezes returns.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (isqrt_x_vld) pq.push_back('{ref_sqrt(isqrt_x), cyc + longint'(lat)});
        mdl_y_vld = 1'b0;
        if (!hold && pq.size() > 0 && pq[0].due <= cyc) begin
            mdl_y_vld = 1'b1;
            mdl_y     = pq[0].y;
            void'(pq.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_vld = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (req_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_req_rdy got %b want 000", req_rdy); end
        n_checks++; if (rsp_vld !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_vld got %b want 000", rsp_vld); end
        n_checks++; if (rsp_y !== '0) begin n_fail++; $display("FAIL reset_rsp_y got %h want 0", rsp_y); end
        n_checks++; if (isqrt_x_vld !== 1'b0) begin n_fail++; $display("FAIL reset_x_vld got %b want 0", isqrt_x_vld); end
        n_checks++; if (isqrt_x !== 32'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", isqrt_x); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_orphan got %b want 0", err_orphan); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int pulses;
        int at;
        do_reset();
        lat = 2;
        req_x = '0;
        req_x[31:0] = 32'd16;
        req_vld = 3'b001;
        @(negedge clk);
        n_checks++; if (req_rdy !== 3'b001) begin n_fail++; $display("FAIL single_grant got %b want 001", req_rdy); end
        tick();
        req_vld = '0;
        @(negedge clk);
        n_checks++; if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd16) begin n_fail++; $display("FAIL single_issue got vld=%b x=%0d want vld=1 x=16", isqrt_x_vld, isqrt_x); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
        pulses = 0;
        at = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_vld !== 3'b000) begin
                pulses++;
                at = c;
                n_checks++; if (rsp_vld !== 3'b001 || rsp_y[15:0] !== 16'd4) begin n_fail++; $display("FAIL single_rsp got vld=%b y=%0d want vld=001 y=4", rsp_vld, rsp_y[15:0]); end
            end
        end
        n_checks++; if (pulses != 1 || at != 2) begin n_fail++; $display("FAIL single_once got pulses=%0d at=%0d want pulses=1 at=2", pulses, at); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_contention;
        int lanes[$];
        logic [15:0] vals[$];
        logic [N-1:0] want;
        int exp_lane[3] = '{0, 1, 2};
        logic [15:0] exp_val[3] = '{16'd2, 16'd3, 16'd5};
        do_reset();
        lat = 3;
        req_x = {32'd25, 32'd9, 32'd4};
        req_vld = 3'b111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            want = '0;
            want[k] = 1'b1;
            n_checks++; if (req_rdy !== want) begin n_fail++; $display("FAIL contention_grant%0d got %b want %b", k, req_rdy, want); end
            tick();
            req_vld[k] = 1'b0;
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rsp_vld[i]) begin
                    lanes.push_back(i);
                    vals.push_back(rsp_y[16*i +: 16]);
                end
            end
        end
        n_checks++; if (lanes.size() != 3) begin n_fail++; $display("FAIL contention_count got %0d want 3", lanes.size()); end
        for (int k = 0; k < 3 && k < lanes.size(); k++) begin
            n_checks++; if (lanes[k] != exp_lane[k] || vals[k] !== exp_val[k]) begin n_fail++; $display("FAIL contention_rsp%0d got lane=%0d y=%0d want lane=%0d y=%0d", k, lanes[k], vals[k], exp_lane[k], exp_val[k]); end
        end
        n_checks++; if (rsp_y !== {16'd5, 16'd3, 16'd2}) begin n_fail++; $display("FAIL contention_hold got %h want 000500030002", rsp_y); end
    endtask

    task automatic test_fairness;
        logic [N-1:0] want;
        do_reset();
        lat = 1;
        req_x = {32'd0, 32'd144, 32'd121};
        req_vld = 3'b011;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            want = (k % 2 == 0) ? 3'b001 : 3'b010;
            n_checks++; if (req_rdy !== want) begin n_fail++; $display("FAIL fair_grant%0d got %b want %b", k, req_rdy, want); end
            tick();
        end
        req_vld = '0;
        for (int c = 0; c < 20 && busy; c++) tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_drain got busy=%b want 0", busy); end
    endtask

    task automatic test_full;
        logic [15:0] got[$];
        int pop_at;
        do_reset();
        lat = 1;
        @(negedge clk);
        hold = 1'b1;
        tick();
        req_x = '0;
        req_vld = 3'b001;
        for (int k = 0; k < 8; k++) begin
            req_x[31:0] = 32'((k + 1) * (k + 1));
            @(negedge clk);
            n_checks++; if (req_rdy !== 3'b001) begin n_fail++; $display("FAIL full_issue%0d got %b want 001", k, req_rdy); end
            tick();
        end
        req_x[31:0] = 32'd81;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (req_rdy !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL full_block%0d got rdy=%b busy=%b want rdy=000 busy=1", k, req_rdy, busy); end
            tick();
        end
        @(negedge clk);
        hold = 1'b0;
        pop_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_vld[0]) got.push_back(rsp_y[15:0]);
            if (pop_at < 0 && isqrt_y_vld) begin
                pop_at = c;
                n_checks++; if (req_rdy !== 3'b000) begin n_fail++; $display("FAIL full_popcycle got %b want 000", req_rdy); end
            end else if (pop_at >= 0 && c == pop_at + 1) begin
                n_checks++; if (req_rdy !== 3'b001) begin n_fail++; $display("FAIL full_reissue got %b want 001", req_rdy); end
            end
            tick();
            if (pop_at >= 0 && c == pop_at + 1) req_vld = '0;
        end
        n_checks++; if (pop_at < 0) begin n_fail++; $display("FAIL full_timeout got no return want return"); end
        n_checks++; if (got.size() != 9) begin n_fail++; $display("FAIL full_count got %0d want 9", got.size()); end
        for (int k = 0; k < got.size() && k < 9; k++) begin
            n_checks++; if (got[k] !== 16'(k + 1)) begin n_fail++; $display("FAIL full_val%0d got %0d want %0d", k, got[k], k + 1); end
        end
        n_checks++; if (busy !== 1'b0 || err_orphan !== 1'b0) begin n_fail++; $display("FAIL full_end got busy=%b orphan=%b want 0 0", busy, err_orphan); end
    endtask

    task automatic test_orphan;
        @(negedge clk);
        n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_pre got %b want 0", err_orphan); end
        model_en  = 1'b0;
        man_y     = 16'h1234;
        man_y_vld = 1'b1;
        tick();
        man_y_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (err_orphan !== 1'b1 || rsp_vld !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL orphan_set got orphan=%b rsp=%b busy=%b want 1 000 0", err_orphan, rsp_vld, busy); end
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        n_checks++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky got %b want 1", err_orphan); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_clear got %b want 0", err_orphan); end
        tick();
        rst_n    = 1'b1;
        model_en = 1'b1;
    endtask

    task automatic test_reset_midop;
        int stray;
        int pulses;
        do_reset();
        lat = 6;
        req_x = {32'd49, 32'd36, 32'd25};
        req_vld = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            req_vld[k] = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || isqrt_x_vld !== 1'b0 || isqrt_x !== 32'd0) begin n_fail++; $display("FAIL midop_rst_issue got busy=%b vld=%b x=%0d want 0 0 0", busy, isqrt_x_vld, isqrt_x); end
        n_checks++; if (rsp_vld !== 3'b000 || rsp_y !== '0 || err_orphan !== 1'b0) begin n_fail++; $display("FAIL midop_rst_rsp got vld=%b y=%h orphan=%b want 0 0 0", rsp_vld, rsp_y, err_orphan); end
        tick();
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_vld !== 3'b000) stray++;
        end
        n_checks++; if (stray != 0 || err_orphan !== 1'b1) begin n_fail++; $display("FAIL midop_orphans got stray=%0d orphan=%b want 0 1", stray, err_orphan); end
        tick();
        req_x[95:64] = 32'd100;
        req_vld = 3'b100;
        @(negedge clk);
        n_checks++; if (req_rdy !== 3'b100) begin n_fail++; $display("FAIL midop_fresh_grant got %b want 100", req_rdy); end
        tick();
        req_vld = '0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_vld !== 3'b000) begin
                pulses++;
                n_checks++; if (rsp_vld !== 3'b100 || rsp_y[47:32] !== 16'd10) begin n_fail++; $display("FAIL midop_fresh_rsp got vld=%b y=%0d want 100 10", rsp_vld, rsp_y[47:32]); end
            end
        end
        n_checks++; if (pulses != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL midop_fresh_done got pulses=%0d busy=%b want 1 0", pulses, busy); end
    endtask

    task automatic test_random;
        exp_t eq[$];
        int mptr;
        int mcount;
        int eg;
        int idx;
        int s;
        logic rsp_due;
        int rsp_lane;
        logic [15:0] rsp_val;
        logic iss_due;
        logic [31:0] iss_x;
        logic [N-1:0] want;
        do_reset();
        mptr = 0; mcount = 0; rsp_due = 1'b0; rsp_lane = 0; rsp_val = '0; iss_due = 1'b0; iss_x = '0;
        for (int t = 0; t < 700; t++) begin
            if (t % 50 == 0) lat = $urandom_range(1, 12);
            if (t < 500) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_vld[i] && $urandom_range(0, 99) < 55) begin
                        req_vld[i] = 1'b1;
                        if ($urandom_range(0, 1) == 0) begin
                            s = $urandom_range(0, 65535);
                            req_x[32*i +: 32] = 32'(s * s);
                        end else begin
                            req_x[32*i +: 32] = $urandom;
                        end
                    end
                end
            end
            @(negedge clk);
            want = '0;
            if (rsp_due) want[rsp_lane] = 1'b1;
            n_checks++; if (rsp_vld !== want) begin n_fail++; $display("FAIL rand_rsp_vld t=%0d got %b want %b", t, rsp_vld, want); end
            if (rsp_due) begin
                n_checks++; if (rsp_y[16*rsp_lane +: 16] !== rsp_val) begin n_fail++; $display("FAIL rand_rsp_y t=%0d got %0d want %0d", t, rsp_y[16*rsp_lane +: 16], rsp_val); end
            end
            n_checks++; if (isqrt_x_vld !== iss_due || (iss_due && isqrt_x !== iss_x)) begin n_fail++; $display("FAIL rand_issue t=%0d got vld=%b x=%h want vld=%b x=%h", t, isqrt_x_vld, isqrt_x, iss_due, iss_x); end
            n_checks++; if (busy !== (mcount != 0) || err_orphan !== 1'b0) begin n_fail++; $display("FAIL rand_status t=%0d got busy=%b orphan=%b want busy=%b orphan=0", t, busy, err_orphan, mcount != 0); end
            eg = -1;
            if (mcount < MI) begin
                for (int k = 0; k < N; k++) begin
                    idx = (mptr + k) % N;
                    if (eg < 0 && req_vld[idx]) eg = idx;
                end
            end
            want = '0;
            if (eg >= 0) want[eg] = 1'b1;
            n_checks++; if (req_rdy !== want) begin n_fail++; $display("FAIL rand_grant t=%0d got %b want %b", t, req_rdy, want); end
            rsp_due = 1'b0;
            if (isqrt_y_vld && mcount > 0) begin
                rsp_due  = 1'b1;
                rsp_lane = eq[0].lane;
                rsp_val  = eq[0].y;
                void'(eq.pop_front());
                mcount--;
            end
            iss_due = 1'b0;
            if (eg >= 0) begin
                iss_due = 1'b1;
                iss_x   = req_x[32*eg +: 32];
                eq.push_back('{eg, ref_sqrt(iss_x)});
                mcount++;
                mptr = (eg + 1) % N;
            end
            tick();
            if (eg >= 0) req_vld[eg] = 1'b0;
        end
        n_checks++; if (mcount != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rand_drain got model=%0d busy=%b want 0 0", mcount, busy); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_vld   = '0;
        req_x     = '0;
        man_y_vld = 1'b0;
        man_y     = '0;
        model_en  = 1'b1;
        hold      = 1'b0;
        lat       = 2;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_full();
        test_orphan();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
